counter_monitor: RTL and testbench

COUNTER_MONITOR -- requirements
Module: counter_monitor

---
 rtl/counter_monitor.sv | 143 ++++++++++++++
 tb/tb_counter_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// Watches an external up-counter, predicts its next {count, overflow} each cycle
// and tracks lock / error status. Define COUNTER_MONITOR_RESYNC_EN to leave ERROR
// after one cycle and resynchronise; without it ERROR holds until reset or clear.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset/clear, first prediction is being captured
// ST_SYNC  | waiting for 2 consecutive samples that match the prediction
// ST_LOCK  | counter tracks the prediction; wraps are counted
// ST_ERROR | a mismatch was seen while locked
module counter_monitor #(
  parameter int WIDTH      = 4,
  parameter int ERR_WIDTH  = 8,
  parameter int WRAP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      count,
  input  logic                  overflow,
  input  logic                  clear,
  output logic                  locked,
  output logic                  error,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [WRAP_WIDTH-1:0] wrap_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_LOCK  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_MAX  = '1;
  localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX  = '1;
  localparam logic [ERR_WIDTH-1:0]  ERR_ONE  = ERR_WIDTH'(1);
  localparam logic [WRAP_WIDTH-1:0] WRAP_ONE = WRAP_WIDTH'(1);

  state_t                state_q, state_d;
  logic                  run_q, run_d;
  logic [WIDTH-1:0]      pred_count_q, pred_count_d;
  logic                  pred_ovf_q, pred_ovf_d;
  logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;
  logic [WRAP_WIDTH-1:0] wrap_count_q, wrap_count_d;
  logic                  locked_q, locked_d;
  logic                  error_q, error_d;
  logic                  sample_match;

  always_comb begin
    pred_count_d = enable ? (count + CNT_ONE) : count;
    pred_ovf_d   = enable && (count == CNT_MAX);
    sample_match = (count == pred_count_q) && (overflow == pred_ovf_q);

    state_d      = state_q;
    run_d        = run_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    if (clear) begin
      state_d      = ST_IDLE;
      run_d        = 1'b0;
      err_count_d  = '0;
      wrap_count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SYNC;
          run_d   = 1'b0;
        end
        ST_SYNC: begin
          // run_q marks one match already seen; a second one locks
          if (sample_match) begin
            if (run_q) begin
              state_d = ST_LOCK;
              run_d   = 1'b0;
            end else begin
              run_d = 1'b1;
            end
          end else begin
            run_d = 1'b0;
          end
        end
        ST_LOCK: begin
          if (sample_match) begin
            if (overflow) begin
              wrap_count_d = wrap_count_q + WRAP_ONE;
            end
          end else begin
            state_d = ST_ERROR;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + ERR_ONE;
            end
          end
        end
        ST_ERROR: begin
`ifdef COUNTER_MONITOR_RESYNC_EN
          state_d = ST_SYNC;
          run_d   = 1'b0;
`else
          state_d = ST_ERROR;
`endif
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = 1'b0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCK);
    error_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      pred_count_q <= '0;
      pred_ovf_q   <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      pred_count_q <= pred_count_d;
      pred_ovf_q   <= pred_ovf_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
    end
  end

  assign locked     = locked_q;
  assign error      = error_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the monitor's rules.
module tb_counter_monitor;
  localparam int W    = 4;
  localparam int EW   = 8;
  localparam int WW   = 16;
  localparam int MODC = 1 << W;
  localparam int CMAX = MODC - 1;
  localparam int EMAX = (1 << EW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_SYNC = 1;
  localparam int M_LOCK = 2;
  localparam int M_ERR  = 3;

  logic          clk = 1'b0;
  logic          reset, enable, overflow, clear;
  logic [W-1:0]  count;
  logic          locked, error;
  logic [EW-1:0] err_count;
  logic [WW-1:0] wrap_count;

  always #5 clk = ~clk;

  counter_monitor #(.WIDTH(W), .ERR_WIDTH(EW), .WRAP_WIDTH(WW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .count     (count),
    .overflow  (overflow),
    .clear     (clear),
    .locked    (locked),
    .error     (error),
    .err_count (err_count),
    .wrap_count(wrap_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_pc, m_po, m_state, m_run, m_err, m_wrap;
  // the well-behaved external counter
  int t_cnt;
  bit t_ovf;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  npc;
    int  npo;
    bit  hit;
    npc = enable ? (int'(count) + 1) % MODC : int'(count);
    npo = (enable && int'(count) == CMAX) ? 1 : 0;
    hit = (int'(count) == m_pc) && (int'(overflow) == m_po);
    if (reset) begin
      m_state = M_IDLE; m_run = 0; m_err = 0; m_wrap = 0; m_pc = 0; m_po = 0;
    end else begin
      if (clear) begin
        m_state = M_IDLE; m_run = 0; m_err = 0; m_wrap = 0;
      end else if (m_state == M_IDLE) begin
        m_state = M_SYNC; m_run = 0;
      end else if (m_state == M_SYNC) begin
        m_run = hit ? m_run + 1 : 0;
        if (m_run == 2) begin
          m_state = M_LOCK; m_run = 0;
        end
      end else if (m_state == M_LOCK) begin
        if (!hit) begin
          m_state = M_ERR;
          if (m_err < EMAX) m_err++;
        end else if (overflow) begin
          m_wrap = (m_wrap + 1) % (1 << WW);
        end
      end else begin
`ifdef COUNTER_MONITOR_RESYNC_EN
        m_state = M_SYNC; m_run = 0;
`endif
      end
      m_pc = npc;
      m_po = npo;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    t_ovf = enable && (t_cnt == CMAX);
    t_cnt = enable ? (t_cnt + 1) % MODC : t_cnt;
    #1;
    chk("locked", int'(locked), (m_state == M_LOCK) ? 1 : 0);
    chk("error", int'(error), (m_state == M_ERR) ? 1 : 0);
    chk("err_count", int'(err_count), m_err);
    chk("wrap_count", int'(wrap_count), m_wrap);
  endtask

  task automatic drive(input bit en);
    enable   = en;
    count    = W'(t_cnt);
    overflow = t_ovf;
  endtask

  task automatic drive_val(input bit en, input int c, input bit o);
    enable   = en;
    count    = W'(c);
    overflow = o;
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (t_cnt != target && guard < 40) begin
      drive(1'b1);
      tick();
      guard++;
    end
    chk("run_to_bound", t_cnt, target);
  endtask

  task automatic wait_lock();
    int guard;
    guard = 0;
    while (m_state != M_LOCK && guard < 20) begin
      drive(1'b1);
      tick();
      guard++;
    end
    chk("lock_wait", int'(locked), 1);
  endtask

  initial begin
    int n_inj;
    reset = 1'b1; clear = 1'b0;
    t_cnt = 0; t_ovf = 1'b0;
    m_state = M_IDLE; m_run = 0; m_err = 0; m_wrap = 0; m_pc = 0; m_po = 0;
    drive(1'b0);
    tick();
    tick();
    chk("rst_locked", int'(locked), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_wrap_count", int'(wrap_count), 0);

    // correct counter for 20 cycles from 0
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1);
      tick();
      if (i == 2) chk("lock_cycle2", int'(locked), 0);
      if (i == 3) chk("lock_cycle3", int'(locked), 1);
    end
    chk("wrap_after_20", int'(wrap_count), 1);
    chk("error_after_20", int'(error), 0);

    // enable low, count held at 9
    run_to(9);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0);
      tick();
      chk("hold_locked", int'(locked), 1);
    end
    chk("hold_wrap", int'(wrap_count), 1);

    // 7 presented while 5 is predicted
    run_to(5);
    drive_val(1'b1, 7, 1'b0);
    tick();
    chk("bad7_error", int'(error), 1);
    chk("bad7_locked", int'(locked), 0);
    chk("bad7_err_count", int'(err_count), 1);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1);
      tick();
`ifndef COUNTER_MONITOR_RESYNC_EN
      chk("sticky_error", int'(error), 1);
`endif
    end
    reset = 1'b1;
    drive(1'b1);
    tick();
    chk("reset_clears_error", int'(error), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1);
      tick();
    end
    chk("relock", int'(locked), 1);

    // 15 -> 0 without overflow
    run_to(15);
    drive(1'b1);
    tick();
    drive_val(1'b1, 0, 1'b0);
    tick();
    chk("no_ovf_error", int'(error), 1);
    chk("no_ovf_err_count", int'(err_count), 1);

    // repeated mismatches, then clear together with a mismatch
    reset = 1'b1;
    drive(1'b1);
    tick();
    reset = 1'b0;
`ifdef COUNTER_MONITOR_RESYNC_EN
    n_inj = 300;
`else
    n_inj = 1;
`endif
    for (int k = 0; k < n_inj; k++) begin
      wait_lock();
      drive_val(1'b1, t_cnt ^ 1, t_ovf);
      tick();
    end
`ifdef COUNTER_MONITOR_RESYNC_EN
    chk("err_saturate", int'(err_count), 255);
`else
    chk("err_single", int'(err_count), 1);
`endif
    clear = 1'b1;
    drive_val(1'b1, t_cnt ^ 3, ~t_ovf);
    tick();
    clear = 1'b0;
    chk("clr_err_count", int'(err_count), 0);
    chk("clr_wrap_count", int'(wrap_count), 0);
    chk("clr_locked", int'(locked), 0);
    chk("clr_error", int'(error), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 128) == 0;
      clear = ($urandom % 64) == 0;
      if (($urandom % 16) == 0) begin
        if ($urandom % 2) drive_val(1'(($urandom % 2)), t_cnt ^ (1 + ($urandom % CMAX)), t_ovf);
        else drive_val(1'($urandom % 2), t_cnt, ~t_ovf);
      end else begin
        drive(1'($urandom % 4 != 0));
      end
      tick();
    end
    reset = 1'b0;
    clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
